// File: rtl/adder_share_sched.sv
// adder_share_sched: time-shares one external combinational W-bit adder between
// two requesters issuing multi-precision additions (least-significant word first).
// A two-state FSM grants one requester round-robin, streams that requester's beats
// through the adder with a carry chained between words, and registers each result word.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready[1:0] per-requester beat handshake
//   req_a0/req_b0, req_a1/req_b1  operand words of requester 0 / 1
//   req_cin[1:0]             carry-in, used on the first beat of a transaction only
//   req_last[1:0]            final beat of a transaction
//   add_a/add_b/add_cin      operands driven to the shared adder
//   add_sum/add_cout         same-cycle result from the shared adder
//   rsp_valid/rsp_ready      result handshake
//   rsp_id/rsp_sum/rsp_cout/rsp_last  registered result word and its attributes
module adder_share_sched #(
  parameter int unsigned W         = 16,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [1:0]   req_cin,
  input  logic [1:0]   req_last,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_last
);

  // Beat counter wide enough for MAX_BEATS up to 15.
  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           owner;
  logic           prio;
  logic           carry;
  logic [CW-1:0]  beat_cnt;

  logic           own_valid_c;
  logic           own_cin_c;
  logic           own_last_c;
  logic [W-1:0]   own_a_c;
  logic [W-1:0]   own_b_c;
  logic           rsp_free_c;
  logic           first_c;
  logic           end_c;
  logic           accept_c;
  logic           grant_c;
  logic           grant_id_c;

  // Owner-selected request view; the non-owner's inputs never reach the datapath.
  always_comb begin
    own_valid_c = owner ? req_valid[1] : req_valid[0];
    own_cin_c   = owner ? req_cin[1]   : req_cin[0];
    own_last_c  = owner ? req_last[1]  : req_last[0];
    own_a_c     = owner ? req_a1       : req_a0;
    own_b_c     = owner ? req_b1       : req_b0;
  end

  // Handshake and transaction-boundary terms.
  always_comb begin
    rsp_free_c = ~rsp_valid | rsp_ready;
    first_c    = (beat_cnt == '0);
    end_c      = own_last_c | (beat_cnt == CW'(MAX_BEATS - 1));
    accept_c   = (state == BUSY) & own_valid_c & rsp_free_c;
    grant_c    = (state == IDLE) & (|req_valid);
    // Both pending: prio holds the requester not served last; otherwise the lone one.
    grant_id_c = (req_valid[0] & req_valid[1]) ? prio : req_valid[1];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req_valid)        state_nxt = BUSY;
      BUSY: if (accept_c && end_c) state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready and adder operands are live only for the owner while BUSY.
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (state == BUSY) begin
      req_ready[owner] = rsp_free_c;
      add_a            = own_a_c;
      add_b            = own_b_c;
      add_cin          = first_c ? own_cin_c : carry;
    end
  end

  // Ownership, arbitration pointer, carry chain and beat counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner    <= 1'b0;
      prio     <= 1'b0;
      carry    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (grant_c) begin
        owner    <= grant_id_c;
        beat_cnt <= '0;
      end
      if (accept_c) begin
        carry <= add_cout;
        if (end_c) begin
          prio     <= ~owner;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  // Result register: loads on acceptance, drains on rsp_ready, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept_c) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
      rsp_id    <= owner;
      rsp_last  <= end_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
`timescale 1ns/1ps
module tb_adder_share_sched;
  localparam int unsigned W    = 16;
  localparam int unsigned MAXB = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         last;
  } beat_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic rsp_ready = 1'b1;

  logic [1:0]   req_valid, req_ready, req_cin, req_last;
  logic [W-1:0] add_a, add_b, add_sum, rsp_sum;
  logic         add_cin, add_cout, rsp_valid, rsp_id, rsp_cout, rsp_last;
  logic [W:0]   add_full;

  assign req_valid = {v1, v0};
  assign req_cin   = {c1, c0};
  assign req_last  = {l1, l0};

  // Shared external adder.
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
  assign add_sum  = add_full[W-1:0];
  assign add_cout = add_full[W];

  adder_share_sched #(.W(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
    .req_cin(req_cin), .req_last(req_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   id_log[$];
  int   acc_log[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic beat_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic last);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.last = last;
    return bt;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic push_exp(input int id, input logic [W-1:0] sum, input logic cout, input logic last);
    exp_t e;
    e.sum = sum; e.cout = cout; e.last = last;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Reference: split the beat stream into transactions (last or MAX_BEATS words),
  // add each as one wide integer, and slice out per-word sums and word carries.
  task automatic model_push(input int id, input beat_t beats[$]);
    int i = 0;
    while (i < beats.size()) begin
      int n = 0;
      logic complete;
      logic [79:0] aa = '0, bb = '0, s, m;
      while (i + n < beats.size()) begin
        n++;
        if (beats[i+n-1].last || n == int'(MAXB)) break;
      end
      complete = beats[i+n-1].last || (n == int'(MAXB));
      for (int k = 0; k < n; k++) begin
        aa = aa | (80'(beats[i+k].a) << (W*k));
        bb = bb | (80'(beats[i+k].b) << (W*k));
      end
      for (int k = 0; k < n; k++) begin
        m = (80'd1 << (W*(k+1))) - 80'd1;
        s = (aa & m) + (bb & m) + 80'(beats[i].cin);
        push_exp(id, s[W*k +: W], s[W*(k+1)], complete && (k == n-1));
      end
      i += n;
    end
  endtask

  task automatic set_req(input int id, input beat_t bt, input logic v);
    if (id == 0) begin v0 = v; a0 = bt.a; b0 = bt.b; c0 = bt.cin; l0 = bt.last; end
    else         begin v1 = v; a1 = bt.a; b1 = bt.b; c1 = bt.cin; l1 = bt.last; end
  endtask

  task automatic go_idle(input int id);
    set_req(id, rnd_beat(), 1'b0);
  endtask

  // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after.
  task automatic send_beat(input int id, input beat_t bt, input int exp_cin);
    logic acc;
    set_req(id, bt, 1'b1);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = req_ready[id];
      if (acc && exp_cin >= 0) check("add_cin_beat", 32'(add_cin), 32'(exp_cin));
      @(posedge clk);
      #1;
      if (acc) break;
      if (t >= 400) begin fail_now("accept_timeout"); break; end
    end
    go_idle(id);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rsp_valid) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 1000) fail_now("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pop on every result handshake, stall stability, operand routing.
  initial begin
    logic held = 1'b0;
    logic [W-1:0] p_sum;
    logic p_cout, p_last, p_id;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_sum",   32'(rsp_sum),  32'(p_sum));
        check("hold_cout",  32'(rsp_cout), 32'(p_cout));
        check("hold_last",  32'(rsp_last), 32'(p_last));
        check("hold_id",    32'(rsp_id),   32'(p_id));
      end
      if (rsp_valid && !rsp_ready) check("stall_req_ready", 32'(req_ready), 32'd0);
      if (rsp_valid && rsp_ready) begin
        id_log.push_back(int'(rsp_id));
        if ((rsp_id == 1'b0 && q0.size() == 0) || (rsp_id == 1'b1 && q1.size() == 0)) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h, required no word", rsp_id, rsp_sum);
        end else begin
          if (rsp_id == 1'b0) e = q0.pop_front();
          else                e = q1.pop_front();
          check("rsp_sum",  32'(rsp_sum),  32'(e.sum));
          check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          check("rsp_last", 32'(rsp_last), 32'(e.last));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          check("add_a_route", 32'(add_a), 32'((i == 0) ? a0 : a1));
          check("add_b_route", 32'(add_b), 32'((i == 0) ? b0 : b1));
          acc_log.push_back(cyc);
        end
      end
      held   = rsp_valid && !rsp_ready;
      p_sum  = rsp_sum;
      p_cout = rsp_cout;
      p_last = rsp_last;
      p_id   = rsp_id;
    end
  end

  initial begin
    beat_t bq[$];
    beat_t bq1[$];
    logic  done;

    // Reset values, sampled while reset is still asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    check("rst_rsp_cout",  32'(rsp_cout),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_last",  32'(rsp_last),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_add_a",   32'(add_a),   32'd0);
    check("idle_add_b",   32'(add_b),   32'd0);
    check("idle_add_cin", 32'(add_cin), 32'd0);
    @(posedge clk);
    #1;

    // Single beat on requester 0, latency 1.
    go_idle(1);
    push_exp(0, 16'h0000, 1'b1, 1'b1);
    send_beat(0, mk(16'h0001, 16'hFFFF, 1'b0, 1'b1), 0);
    @(negedge clk);
    check("lat1_valid", 32'(rsp_valid), 32'd1);
    check("lat1_id",    32'(rsp_id),    32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Two-beat carry chain on requester 1.
    push_exp(1, 16'h0000, 1'b1, 1'b0);
    push_exp(1, 16'h0001, 1'b0, 1'b1);
    send_beat(1, mk(16'hFFFF, 16'h0001, 1'b0, 1'b0), 0);
    send_beat(1, mk(16'h0000, 16'h0000, 1'b0, 1'b1), 1);
    wait_drain();

    // Round-robin from reset with both requesters always pending.
    do_reset();
    id_log.delete();
    acc_log.delete();
    bq.delete();
    bq1.delete();
    for (int k = 0; k < 2; k++) begin
      bq.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b1));
      bq1.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b1));
    end
    model_push(0, bq);
    model_push(1, bq1);
    fork
      begin send_beat(0, bq[0], -1);  send_beat(0, bq[1], -1);  end
      begin send_beat(1, bq1[0], -1); send_beat(1, bq1[1], -1); end
    join
    wait_drain();
    check("rr_count", 32'(id_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < id_log.size(); k++) check("rr_order", 32'(id_log[k]), 32'(k % 2));
    for (int k = 1; k < acc_log.size(); k++) check("rr_gap", 32'(acc_log[k] - acc_log[k-1]), 32'd2);

    // Truncation at MAX_BEATS: beats 5 and 6 form a new transaction with beat 5's cin.
    bq.delete();
    for (int k = 0; k < 4; k++) bq.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b0));
    bq.push_back(mk(16'hFFFF, 16'h0000, 1'b1, 1'b0));
    bq.push_back(mk(W'($urandom), W'($urandom), 1'b0, 1'b1));
    model_push(0, bq);
    for (int k = 0; k < 6; k++) send_beat(0, bq[k], (k == 4) ? 1 : -1);
    wait_drain();

    // Back-pressure: rsp_ready low for three cycles while a result is pending.
    rsp_ready = 1'b0;
    bq.delete();
    for (int k = 0; k < 3; k++) bq.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), k == 2));
    model_push(0, bq);
    fork
      begin for (int k = 0; k < 3; k++) send_beat(0, bq[k], -1); end
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!rsp_valid && t < 100);
        if (t >= 100) fail_now("stall_wait");
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized traffic on both requesters with random back-pressure and gaps.
    bq.delete();
    bq1.delete();
    for (int k = 0; k < 30; k++) begin
      bq.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) || k == 29));
      bq1.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) || k == 29));
    end
    model_push(0, bq);
    model_push(1, bq1);
    done = 1'b0;
    fork
      begin
        fork
          begin
            foreach (bq[k]) begin
              if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
              send_beat(0, bq[k], -1);
            end
          end
          begin
            foreach (bq1[k]) begin
              if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
              send_beat(1, bq1[k], -1);
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a three-beat transaction.
    do_reset();
    bq.delete();
    bq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0));
    model_push(0, bq);
    send_beat(0, bq[0], 0);
    set_req(0, mk(16'h0000, 16'h0000, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_add_a",     32'(add_a),     32'd0);
    @(posedge clk);
    #1;
    bq.delete();
    bq.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0));
    bq.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1));
    model_push(0, bq);
    send_beat(0, bq[0], 0);
    send_beat(0, bq[1], 0);
    wait_drain();

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
